// File: rtl/brew_timer.sv
// brew_timer: brew-cycle countdown timer feeding the 7-seg display; build with BREW_TIMER_PAUSE_EN for pause.
module brew_timer #(
  parameter int TICKS_PER_SEC = 50_000_000,
  parameter int DONE_SEC = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       cancel,
  input  logic       pause,
  input  logic [3:0] duration,
  output logic [3:0] remaining,
  output logic       busy,
  output logic       done
);
  localparam int PW = $clog2(TICKS_PER_SEC);
  localparam int HW = $clog2(DONE_SEC + 1);
  localparam logic [PW-1:0] PSC_LAST = PW'(TICKS_PER_SEC - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(DONE_SEC - 1);
  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;
  state_t state_q, state_d;
  logic [PW-1:0] psc_q, psc_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [3:0] rem_q, rem_d;
  logic busy_q, busy_d, done_q, done_d;
  logic pause_en, cnt_en, tick, active, go, entry;
`ifdef BREW_TIMER_PAUSE_EN
  assign pause_en = pause;
`else
  logic pause_unused;
  assign pause_unused = pause;
  assign pause_en = 1'b0;
`endif
  assign active = state_q == RUN || state_q == PAUSE;
  assign go = start && duration != 4'd0;
  // A paused cycle never advances the prescaler, so pause time adds exactly.
  assign cnt_en = state_q == DONE || (active && !pause_en);
  assign tick = cnt_en && psc_q == PSC_LAST;
  assign remaining = rem_q;
  assign busy = busy_q;
  assign done = done_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      psc_q <= '0;
      hold_q <= '0;
      rem_q <= 4'd0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      psc_q <= psc_d;
      hold_q <= hold_d;
      rem_q <= rem_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end
  always_comb begin
    state_d = state_q;
    if (cancel) state_d = IDLE;
    else case (state_q)
      IDLE: state_d = go ? RUN : IDLE;
      RUN, PAUSE: state_d = pause_en ? PAUSE : (tick && rem_q == 4'd1) ? DONE : RUN;
      DONE: state_d = go ? RUN : (tick && hold_q == HOLD_LAST) ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  // RUN<->PAUSE keeps the prescaler; every other state change restarts it.
  always_comb begin
    entry = state_d != state_q && !(active && (state_d == RUN || state_d == PAUSE));
    psc_d = entry ? '0 : !cnt_en ? psc_q : tick ? '0 : psc_q + 1'b1;
    hold_d = (state_d != DONE || state_q != DONE) ? '0 : tick ? hold_q + 1'b1 : hold_q;
    rem_d = state_d == IDLE ? duration :
            state_d == DONE ? 4'd0 :
            (state_q == IDLE || state_q == DONE) ? duration :
            (tick && rem_q != 4'd0) ? rem_q - 4'd1 : rem_q;
    busy_d = state_d == RUN || state_d == PAUSE;
    done_d = active && state_d == DONE;
  end
endmodule

// File: tb/tb_brew_timer.sv
// tb_brew_timer: directed checks of brew_timer with TICKS_PER_SEC=4, DONE_SEC=2.
module tb_brew_timer;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, cancel = 1'b0, pause = 1'b0;
  logic [3:0] duration = 4'd3;
  logic [3:0] remaining;
  logic busy, done;
  int total = 0, bad = 0;
  brew_timer #(.TICKS_PER_SEC(4), .DONE_SEC(2)) dut (
    .clk(clk), .rst(rst), .start(start), .cancel(cancel), .pause(pause),
    .duration(duration), .remaining(remaining), .busy(busy), .done(done)
  );
  always #5 clk = ~clk;
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  initial begin
    int saw, first, exp_done;
    #2;
    chk("rst_rem", remaining, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    step(1);
    rst = 1'b0;
    step(1);
    chk("idle_preview", remaining, 3);
    start = 1'b1;
    step(1);
    start = 1'b0;
    chk("t1_busy", busy, 1);
    chk("t1_rem0", remaining, 3);
    step(3);
    chk("t1_rem3", remaining, 3);
    step(1);
    chk("t1_rem4", remaining, 2);
    step(4);
    chk("t1_rem8", remaining, 1);
    step(3);
    chk("t1_done11", done, 0);
    chk("t1_busy11", busy, 1);
    step(1);
    chk("t1_rem12", remaining, 0);
    chk("t1_done12", done, 1);
    chk("t1_busy12", busy, 0);
    step(1);
    chk("t1_done13", done, 0);
    step(6);
    chk("t1_hold19", remaining, 0);
    step(1);
    chk("t1_idle20", remaining, 3);
    duration = 4'd0;
    start = 1'b1;
    step(1);
    start = 1'b0;
    chk("t2_busy", busy, 0);
    chk("t2_rem", remaining, 0);
    saw = 0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      saw |= done | busy;
    end
    chk("t2_quiet", saw, 0);
    duration = 4'd15;
    start = 1'b1;
    step(1);
    start = 1'b0;
    step(5);
    chk("t3_rem5", remaining, 14);
    cancel = 1'b1;
    step(1);
    cancel = 1'b0;
    chk("t3_busy", busy, 0);
    chk("t3_done", done, 0);
    chk("t3_rem", remaining, 15);
    duration = 4'd7;
    step(1);
    chk("t3_track", remaining, 7);
    duration = 4'd4;
    start = 1'b1;
    cancel = 1'b1;
    step(1);
    start = 1'b0;
    cancel = 1'b0;
    chk("t4_nostart", busy, 0);
    chk("t4_rem", remaining, 4);
    duration = 4'd2;
    start = 1'b1;
    step(1);
    start = 1'b0;
    step(2);
    duration = 4'd9;
    start = 1'b1;
    step(1);
    start = 1'b0;
    chk("t4_restart_busy", busy, 1);
    chk("t4_restart_rem", remaining, 2);
    step(4);
    chk("t4_rem7", remaining, 1);
    chk("t4_done7", done, 0);
    step(1);
    chk("t4_done8", done, 1);
    chk("t4_rem8", remaining, 0);
    start = 1'b1;
    step(1);
    start = 1'b0;
    chk("t4_redo_busy", busy, 1);
    chk("t4_redo_rem", remaining, 9);
    cancel = 1'b1;
    step(1);
    cancel = 1'b0;
    chk("t4_cancel_busy", busy, 0);
    duration = 4'd2;
    start = 1'b1;
    step(1);
    start = 1'b0;
    step(2);
    pause = 1'b1;
    step(5);
    pause = 1'b0;
    chk("t5_busy_paused", busy, 1);
    first = -1;
    for (int i = 8; i <= 15; i++) begin
      step(1);
      if (done && first < 0) first = i;
    end
`ifdef BREW_TIMER_PAUSE_EN
    exp_done = 13;
`else
    exp_done = 8;
`endif
    chk("t5_done_edge", first, exp_done);
    cancel = 1'b1;
    step(1);
    cancel = 1'b0;
    duration = 4'd5;
    start = 1'b1;
    step(1);
    start = 1'b0;
    step(2);
    chk("t6_rem", remaining, 5);
    #2 rst = 1'b1;
    #1;
    chk("t6_async_rem", remaining, 0);
    chk("t6_async_busy", busy, 0);
    #1 rst = 1'b0;
    duration = 4'd1;
    start = 1'b1;
    step(1);
    start = 1'b0;
    chk("t6_busy", busy, 1);
    chk("t6_rem", remaining, 1);
    step(3);
    chk("t6_done3", done, 0);
    step(1);
    chk("t6_done4", done, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/brew_timer.md
# brew_timer

Countdown timer for the coffee maker brew cycle. Latches a brew duration in seconds (1–15) on a start pulse and counts down once per second from a clock prescaler. Drives its 4-bit remaining count directly into the `in` port of the seven-segment display driver. Also reports busy/done status to the brew controller.

## Interface
Parameters:
- `TICKS_PER_SEC`, default 50_000_000: clock cycles per one-second tick. Must be ≥2.
- `DONE_SEC`, default 3: whole seconds the DONE state holds the display at 0 before returning to IDLE. Must be ≥1.

Ports:
- `clk`  input  1: system clock; all state changes on its rising edge.
- `rst`  input  1: reset, asynchronous, active-high.
- `start`  input  1: one-cycle request to begin a brew countdown.
- `cancel`  input  1: abort request; level-sampled each cycle.
- `pause`  input  1: hold the countdown while high. Functional only with `BREW_TIMER_PAUSE_EN`.
- `duration`  input  4: preset brew time in seconds.
- `remaining`  output  4: value for the display, 0–15. Registered.
- `busy`  output  1: high in RUN and PAUSE. Registered.
- `done`  output  1: one-cycle pulse on countdown completion. Registered.

## Operation
- States: IDLE, RUN, PAUSE, DONE. Reset puts the block in IDLE with prescaler=0, `remaining`=0, `busy`=0, `done`=0, hold counter=0.
- Prescaler: counts 0..`TICKS_PER_SEC`-1 in RUN and DONE. A tick fires when the count equals `TICKS_PER_SEC`-1; the count then wraps to 0. The prescaler is cleared on every state entry.
- IDLE:
  - `remaining` <= `duration` every cycle (preview of the preset).
  - `start`=1 with `duration`≠0 → RUN, `remaining` <= `duration`.
  - `start` with `duration`=0 is ignored.
- RUN:
  - On tick: `remaining` <= `remaining`-1.
  - If a tick fires while `remaining`=1 → DONE, `remaining` <= 0, `done`=1 for the next cycle only.
  - `start` is ignored. `duration` changes have no effect until the next IDLE.
- PAUSE (macro only):
  - Entered from RUN when `pause`=1. The prescaler and `remaining` freeze.
  - `pause`=0 → RUN, resuming from the frozen prescaler value (not cleared).
- DONE:
  - `remaining` is held at 0. After `DONE_SEC` ticks → IDLE.
  - `start` with `duration`≠0 → RUN directly (restart).
- Priority each cycle: `rst` > `cancel` > `start` > `pause` > tick.
  - `cancel` in any non-IDLE state → IDLE next edge with no `done` pulse. In IDLE, `cancel` has no effect.
  - `cancel` and `start` in the same cycle: cancel wins and the block stays or goes to IDLE.
- Width rules:
  - `remaining` never underflows: a decrement happens only when `remaining`≥1.
  - The prescaler is `$clog2(TICKS_PER_SEC)` bits.
  - The hold counter is `$clog2(DONE_SEC+1)` bits.

## Timing
- `start` sampled at edge E0 → `busy`=1 and `remaining`=`duration` visible after E0.
- Decrements occur at edges E0 + k·`TICKS_PER_SEC`, for k=1..`duration`.
- `done` is high for exactly one cycle after edge E0 + `duration`·`TICKS_PER_SEC`. `busy` falls on that same edge.
- Return to IDLE happens `DONE_SEC`·`TICKS_PER_SEC` cycles after DONE entry.
- Pause time adds to the total cycle count exactly: a pause lasting P cycles delays `done` by P cycles.
- Reset asserted mid-operation clears all outputs immediately (asynchronously). The first edge after reset release behaves as IDLE.
- No combinational path from inputs to outputs.

## Configuration
- `BREW_TIMER_PAUSE_EN` defined: the PAUSE state and `pause` input are functional as described above.
- Not defined: the `pause` port remains on the interface but is ignored, no PAUSE state is synthesized, and RUN never freezes.

## Test plan
Run the bench with `TICKS_PER_SEC`=4 and `DONE_SEC`=2.
- Reset, then `duration`=3 and `start` pulse → `remaining` reads 3, 2, 1, 0 at edges +4, +8, +12. `done` is a single pulse after edge +12, and `busy` falls on that edge. The block returns to IDLE 8 cycles later and shows 3 again.
- `start` with `duration`=0 → state stays IDLE, `busy`=0, `done` never asserts.
- `duration`=15 with `start`, then `cancel` at cycle 6 → IDLE next edge, `busy`=0, no `done`, `remaining` tracks `duration`.
- `start` and `cancel` in the same cycle → no RUN entry. A second `start` during RUN is ignored, and `done` timing is unchanged.
- With the macro: `duration`=2, `pause` high for 5 cycles at cycle 2 → `done` fires 5 cycles later than unpaused (edge +13). Without the macro → `done` at edge +8.
- Assert `rst` mid-RUN (`remaining`=5) between edges → all outputs are 0 immediately. After release, a `start` with `duration`=1 gives `done` after 4 cycles.
